// File: rtl/shift_rotate_unit.sv
// Multi-cycle shifter/rotator moving up to STEP bits per cycle through IDLE -> SHIFT -> DONE.
// Optional abort input enabled by defining SRU_ABORT_EN.
module shift_rotate_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 4
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] amt,
`ifdef SRU_ABORT_EN
   input  logic             abort,
`endif
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   localparam int unsigned LW = $clog2(WIDTH);
   localparam int unsigned RW = LW + 1;
   localparam logic [RW-1:0]    WIDTH_R = RW'(WIDTH);
   localparam logic [RW-1:0]    STEP_R  = RW'(STEP);
   localparam logic [WIDTH-1:0] WIDTH_A = WIDTH'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   typedef enum logic [2:0] {
      OP_SHR  = 3'b000,
      OP_SHRA = 3'b001,
      OP_SHL  = 3'b010,
      OP_ROR  = 3'b011,
      OP_ROL  = 3'b100
   } op_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  work_q, work_d;
   logic [2:0]        mode_q, mode_d;
   logic [RW-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              carry_q, carry_d;

   logic [RW-1:0]     k;
   logic [RW-1:0]     n;
   logic [RW-1:0]     hi_idx;
   logic [LW-1:0]     lo_idx;
   logic [WIDTH-1:0]  shr_val, sra_val, shl_val, ror_val, rol_val;
   logic [WIDTH-1:0]  step_val;
   logic              step_carry;
   logic              last_step;
   logic              abort_i;

`ifdef SRU_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   // Effective amount: rotates wrap modulo WIDTH, shifts saturate at WIDTH.
   always_comb begin
      k = '0;
      case (mode)
         OP_SHR, OP_SHRA, OP_SHL: k = (amt >= WIDTH_A) ? WIDTH_R : {1'b0, amt[LW-1:0]};
         OP_ROR, OP_ROL:          k = {1'b0, amt[LW-1:0]};
         default:                 k = '0;
      endcase
   end

   // One partial step; rotate carry of the final step equals the result end bit.
   always_comb begin
      n          = (rem_q > STEP_R) ? STEP_R : rem_q;
      lo_idx     = LW'(n - RW'(1));
      hi_idx     = WIDTH_R - n;
      shr_val    = work_q >> n;
      sra_val    = $signed(work_q) >>> n;
      shl_val    = work_q << n;
      ror_val    = (work_q >> n) | (work_q << hi_idx);
      rol_val    = (work_q << n) | (work_q >> hi_idx);
      last_step  = (rem_q == n);
      step_val   = work_q;
      step_carry = 1'b0;
      case (mode_q)
         OP_SHR: begin
            step_val   = shr_val;
            step_carry = work_q[lo_idx];
         end
         OP_SHRA: begin
            step_val   = sra_val;
            step_carry = work_q[lo_idx];
         end
         OP_SHL: begin
            step_val   = shl_val;
            step_carry = work_q[hi_idx[LW-1:0]];
         end
         OP_ROR: begin
            step_val   = ror_val;
            step_carry = ror_val[WIDTH-1];
         end
         OP_ROL: begin
            step_val   = rol_val;
            step_carry = rol_val[0];
         end
         default: begin
            step_val   = work_q;
            step_carry = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (k == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (last_step) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready  = (state_q == S_IDLE);
      busy   = (state_q == S_SHIFT);
      done   = (state_q == S_DONE);
      result = result_q;
      carry  = carry_q;
   end

   always_comb begin
      work_d   = work_q;
      mode_d   = mode_q;
      rem_d    = rem_q;
      result_d = result_q;
      carry_d  = carry_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               work_d = a;
               mode_d = mode;
               rem_d  = k;
               if (k == '0) begin
                  result_d = a;
                  carry_d  = 1'b0;
               end
            end
         end
         S_SHIFT: begin
            if (!abort_i) begin
               work_d = step_val;
               rem_d  = rem_q - n;
               if (last_step) begin
                  result_d = step_val;
                  carry_d  = step_carry;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         work_q   <= '0;
         mode_q   <= '0;
         rem_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
      end else begin
         work_q   <= work_d;
         mode_q   <= mode_d;
         rem_q    <= rem_d;
         result_q <= result_d;
         carry_q  <= carry_d;
      end
   end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Bench for shift_rotate_unit: spec-level model compared every cycle plus directed literal vectors.
module tb_shift_rotate_unit;

   localparam int W = 32;
   localparam int S = 4;

   logic          clock   = 1'b0;
   logic          clear_n = 1'b1;
   logic          start   = 1'b0;
   logic [2:0]    mode    = '0;
   logic [W-1:0]  a       = '0;
   logic [W-1:0]  amt     = '0;
`ifdef SRU_ABORT_EN
   logic          abort   = 1'b0;
`endif
   logic          ready, busy, done, carry;
   logic [W-1:0]  result;

   int checks = 0;
   int errors = 0;

   shift_rotate_unit #(.WIDTH(W), .STEP(S)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .start   (start),
      .mode    (mode),
      .a       (a),
      .amt     (amt),
`ifdef SRU_ABORT_EN
      .abort   (abort),
`endif
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .carry   (carry)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [W-1:0] res;
      logic         carry;
      logic [7:0]   cyc;
   } exp_t;

   // Whole-operation result from the arithmetic definition of each mode.
   function automatic exp_t model(input logic [2:0] m, input logic [W-1:0] x, input logic [W-1:0] s);
      exp_t        e;
      int          k;
      logic [63:0] dbl;
      e.res   = x;
      e.carry = 1'b0;
      dbl     = {x, x};
      case (m)
         3'd0, 3'd1, 3'd2: k = (s >= 32'd32) ? 32 : int'(s);
         3'd3, 3'd4:       k = int'(s % 32'd32);
         default:          k = 0;
      endcase
      if (k != 0) begin
         case (m)
            3'd0: begin
               e.res   = (k == 32) ? '0 : (x >> k);
               e.carry = x[k-1];
            end
            3'd1: begin
               e.res   = (k == 32) ? {W{x[W-1]}} : W'($signed(x) >>> k);
               e.carry = x[k-1];
            end
            3'd2: begin
               e.res   = (k == 32) ? '0 : (x << k);
               e.carry = x[32-k];
            end
            3'd3: begin
               dbl     = dbl >> k;
               e.res   = dbl[31:0];
               e.carry = e.res[W-1];
            end
            3'd4: begin
               dbl     = dbl << k;
               e.res   = dbl[63:32];
               e.carry = e.res[0];
            end
            default: begin
            end
         endcase
      end
      e.cyc = 8'((k + S - 1) / S);
      return e;
   endfunction

   exp_t cur_exp;
   assign cur_exp = model(mode, a, amt);

   logic [7:0]   m_busy  = '0;
   logic         m_done  = 1'b0;
   logic [W-1:0] m_res   = '0;
   logic         m_carry = 1'b0;
   exp_t         pend    = '0;
   logic         m_abort;
`ifdef SRU_ABORT_EN
   assign m_abort = abort;
`else
   assign m_abort = 1'b0;
`endif

   always @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         m_busy  <= '0;
         m_done  <= 1'b0;
         m_res   <= '0;
         m_carry <= 1'b0;
         pend    <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_busy != 0) begin
         if (m_abort) begin
            m_busy <= '0;
         end else if (m_busy == 8'd1) begin
            m_busy  <= '0;
            m_done  <= 1'b1;
            m_res   <= pend.res;
            m_carry <= pend.carry;
         end else begin
            m_busy <= m_busy - 8'd1;
         end
      end else if (start) begin
         if (cur_exp.cyc == 0) begin
            m_done  <= 1'b1;
            m_res   <= cur_exp.res;
            m_carry <= cur_exp.carry;
         end else begin
            m_busy <= cur_exp.cyc;
            pend   <= cur_exp;
         end
      end
   end

   always @(negedge clock) begin
      chk("ready",  64'(ready),  64'((m_busy == 0) && !m_done));
      chk("busy",   64'(busy),   64'(m_busy != 0));
      chk("done",   64'(done),   64'(m_done));
      chk("result", 64'(result), 64'(m_res));
      chk("carry",  64'(carry),  64'(m_carry));
   end

   task automatic launch(input logic [2:0] m, input logic [W-1:0] av, input logic [W-1:0] sv);
      start = 1'b1;
      mode  = m;
      a     = av;
      amt   = sv;
      @(posedge clock);
   endtask

   task automatic finish(input string name, input logic [W-1:0] er, input logic ec,
                         input int elat, input bit hold);
      int lat  = 0;
      bit seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clock);
         lat++;
         if (!hold) start = 1'b0;
         if (done) seen = 1'b1;
      end
      chk({name, " done_seen"}, 64'(seen), 64'd1);
      chk({name, " latency"}, 64'(lat), 64'(elat));
      chk({name, " result"}, 64'(result), 64'(er));
      chk({name, " carry"}, 64'(carry), 64'(ec));
   endtask

   typedef struct {
      logic [2:0]   m;
      logic [W-1:0] av;
      logic [W-1:0] sv;
      logic [W-1:0] er;
      logic         ec;
      int           lat;
   } vec_t;

   vec_t vecs[10] = '{
      '{3'b011, 32'hCDFFFFAB, 32'd8,   32'hABCDFFFF, 1'b1, 3},
      '{3'b001, 32'h80000000, 32'd4,   32'hF8000000, 1'b0, 2},
      '{3'b010, 32'h00000001, 32'd31,  32'h80000000, 1'b0, 9},
      '{3'b100, 32'h12345678, 32'd36,  32'h23456781, 1'b1, 2},
      '{3'b000, 32'hFFFFFFFF, 32'd40,  32'h00000000, 1'b1, 9},
      '{3'b000, 32'hDEADBEEF, 32'd0,   32'hDEADBEEF, 1'b0, 1},
      '{3'b111, 32'hCAFEF00D, 32'd5,   32'hCAFEF00D, 1'b0, 1},
      '{3'b010, 32'h80000001, 32'd1,   32'h00000002, 1'b1, 2},
      '{3'b011, 32'h0F0F0F0F, 32'd32,  32'h0F0F0F0F, 1'b0, 1},
      '{3'b001, 32'h80000000, 32'd100, 32'hFFFFFFFF, 1'b1, 9}
   };

   initial begin
      #1 clear_n = 1'b0;
      #2;
      chk("reset ready",  64'(ready),  64'd1);
      chk("reset busy",   64'(busy),   64'd0);
      chk("reset done",   64'(done),   64'd0);
      chk("reset result", 64'(result), 64'd0);
      chk("reset carry",  64'(carry),  64'd0);
      @(negedge clock);
      #2 clear_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clock);
         launch(vecs[i].m, vecs[i].av, vecs[i].sv);
         finish($sformatf("vec%0d", i), vecs[i].er, vecs[i].ec, vecs[i].lat, 1'b0);
      end

      // start held through SHIFT and DONE: one op, then a second accepted in the next IDLE
      @(negedge clock);
      launch(3'b011, 32'hCDFFFFAB, 32'd8);
      finish("hold1", 32'hABCDFFFF, 1'b1, 3, 1'b1);
      mode = 3'b100;
      a    = 32'h12345678;
      amt  = 32'd36;
      @(posedge clock);
      @(negedge clock);
      chk("hold idle ready", 64'(ready), 64'd1);
      chk("hold idle busy",  64'(busy),  64'd0);
      @(posedge clock);
      finish("hold2", 32'h23456781, 1'b1, 2, 1'b0);

`ifdef SRU_ABORT_EN
      @(negedge clock);
      launch(3'b011, 32'hCDFFFFAB, 32'd8);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk("abort ready",  64'(ready),  64'd1);
      chk("abort done",   64'(done),   64'd0);
      chk("abort result", 64'(result), 64'h23456781);
      chk("abort carry",  64'(carry),  64'd1);
      repeat (3) begin
         @(negedge clock);
         chk("abort no done", 64'(done), 64'd0);
      end
`endif

      // reset mid-SHIFT discards the op and clears the held result
      @(negedge clock);
      launch(3'b010, 32'h00000001, 32'd31);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      #2 clear_n = 1'b0;
      #1;
      chk("midrst ready",  64'(ready),  64'd1);
      chk("midrst busy",   64'(busy),   64'd0);
      chk("midrst done",   64'(done),   64'd0);
      chk("midrst result", 64'(result), 64'd0);
      chk("midrst carry",  64'(carry),  64'd0);
      @(negedge clock);
      #2 clear_n = 1'b1;
      launch(3'b011, 32'h000000F1, 32'd4);
      finish("post reset", 32'h1000000F, 1'b0, 2, 1'b0);

      repeat (3) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_rotate_unit.md
SHIFT_ROTATE_UNIT -- requirements
Module: shift_rotate_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; power of 2, 8..64.
REQ-002 SHALL have parameter STEP, default 4, maximum bits moved per SHIFT cycle; power of 2, 1..WIDTH.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port clear_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port mode  input  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 pass-through.
REQ-007 SHALL have port a  input  WIDTH  operand to shift or rotate.
REQ-008 SHALL have port amt  input  WIDTH  shift/rotate amount, full register value.
REQ-009 SHALL have port ready  output  1  high exactly in IDLE.
REQ-010 SHALL have port busy  output  1  high exactly in SHIFT.
REQ-011 SHALL have port done  output  1  one-cycle pulse in DONE.
REQ-012 SHALL have port result  output  WIDTH  registered result; held until next completion.
REQ-013 SHALL have port carry  output  1  last bit shifted or wrapped out; held with result.

Function
REQ-014 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE; DONE lasts exactly one cycle.
REQ-015 SHALL, on a rising edge in IDLE with start=1, capture a, mode and effective amount k into internal registers; later input changes are ignored.
REQ-016 SHALL ignore start in SHIFT and DONE; no queuing.
REQ-017 SHALL compute k = amt mod WIDTH for ROR/ROL, k = min(amt, WIDTH) for SHR/SHRA/SHL, k = 0 for pass-through codes.
REQ-018 SHALL go IDLE -> DONE directly when k=0; result = a, carry = 0.
REQ-019 SHALL, in SHIFT, move min(STEP, remaining) bits per cycle, decrement remaining by that count, and enter DONE when remaining reaches 0.
REQ-020 SHALL assert done exactly ceil(k/STEP)+1 cycles after the accepting edge; busy is high for ceil(k/STEP) cycles.
REQ-021 SHALL zero-fill for SHR/SHL, sign-fill for SHRA, wrap bits for ROR/ROL.
REQ-022 SHALL define carry as: SHR/SHRA = last bit shifted out of LSB end; SHL = last bit shifted out of MSB end; ROR = result[WIDTH-1]; ROL = result[0].
REQ-023 SHALL update result and carry only on the edge entering DONE; a working register holds intermediate values.
REQ-024 SHALL accept start on the first IDLE cycle after DONE, giving back-to-back throughput of ceil(k/STEP)+2 cycles.

Reset
REQ-025 SHALL, while clear_n=0, force state IDLE, ready=1, busy=0, done=0, result=0, carry=0, and clear all internal registers.
REQ-026 SHALL discard an in-flight operation when clear_n falls mid-SHIFT; no done pulse follows.
REQ-027 SHALL accept start on the first rising edge after clear_n deasserts.

Configuration
REQ-028 SHALL, with SRU_ABORT_EN defined, add input abort (1 bit): abort=1 in SHIFT returns to IDLE on the next edge without done, with result and carry unchanged; abort is ignored in IDLE and DONE.
REQ-029 SHALL, without SRU_ABORT_EN, have no abort port; every accepted operation completes.

Verification
REQ-030 SHALL check ROR: a=0xCDFFFFAB, amt=8, WIDTH=32, STEP=4 -> result 0xABCDFFFF, carry 1, done 3 cycles after accept.
REQ-031 SHALL check SHRA and SHL: SHRA a=0x80000000, amt=4 -> 0xF8000000, carry 0, done at +2; SHL a=0x00000001, amt=31 -> 0x80000000, carry 0, done at +9.
REQ-032 SHALL check amount edges: ROL a=0x12345678, amt=36 -> 0x23456781, carry 1, done at +2; SHR a=0xFFFFFFFF, amt=40 -> 0x00000000, carry 1; amt=0 or mode=111 -> result=a, done at +1.
REQ-033 SHALL check handshake: start held high through SHIFT and DONE -> exactly one operation; a second start in the first IDLE after DONE is accepted.
REQ-034 SHALL check reset: clear_n pulsed low mid-SHIFT -> all outputs at reset values immediately, no done pulse, previous result lost (0).
REQ-035 SHALL check, with SRU_ABORT_EN defined: abort in 2nd SHIFT cycle of the REQ-030 operation -> IDLE next edge, no done pulse, result and carry keep their prior values.
